// File: rtl/seq_pattern_tx.sv
// Serial pattern generator driving a sequence-detector input: sends 1..8 latched
// bits per frame, idles GAP_CYCLES cycles, then repeats or reports completion.
//
// state | meaning
// IDLE  | waiting for start; ready=1
// SEND  | shifting latched pattern onto x1, one bit per cycle
// GAP   | x1 held low for GAP_CYCLES cycles between frames
// DONE  | one-cycle done pulse before returning to IDLE
module seq_pattern_tx #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  input  logic [2:0] len,
  input  logic       repeat_en,
  input  logic       abort,
  output logic       x1,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [2:0] bit_idx,
  output logic [3:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_e     state_q;
  logic [7:0] pat_q;
  logic [2:0] len_q;
  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic [3:0] gap_q;
  logic       x1_q;
  logic       ready_q;
  logic       busy_q;
  logic       done_q;
  logic [3:0] frame_cnt_q;

  // Bit k of a frame of n+1 bits, in the configured transmit order.
  function automatic logic pick_bit(input logic [7:0] pat, input logic [2:0] n,
                                    input logic [2:0] k);
    logic [2:0] pos;
    pos = MSB_FIRST ? (n - k) : k;
    return pat[pos];
  endfunction

  assign idx_d = idx_q + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pat_q       <= 8'd0;
      len_q       <= 3'd0;
      idx_q       <= 3'd0;
      gap_q       <= 4'd0;
      x1_q        <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= 4'd0;
    end else if (abort) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      x1_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SEND;
            pat_q   <= data;
            len_q   <= len;
            idx_q   <= 3'd0;
            x1_q    <= pick_bit(data, len, 3'd0);
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          if (idx_q == len_q) begin
            state_q     <= GAP;
            gap_q       <= GAP_LAST;
            idx_q       <= 3'd0;
            x1_q        <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 4'd1;
          end else begin
            idx_q <= idx_d;
            x1_q  <= pick_bit(pat_q, len_q, idx_d);
          end
        end
        GAP: begin
          if (gap_q == 4'd0) begin
            // Repeats reuse the latched pattern; live data/len are not looked at.
            if (repeat_en) begin
              state_q <= SEND;
              x1_q    <= pick_bit(pat_q, len_q, 3'd0);
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          x1_q    <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x1        = x1_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bit_idx   = idx_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: a vector table for reset/idle behaviour
// plus scoreboarded frame sequences for both bit orders.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst, start, repeat_en, abort;
  logic [7:0] data;
  logic [2:0] len;

  logic       x1_m, ready_m, busy_m, done_m;
  logic [2:0] idx_m;
  logic [3:0] fc_m;
  logic       x1_l, ready_l, busy_l, done_l;
  logic [2:0] idx_l;
  logic [3:0] fc_l;

  always #5 clk = ~clk;

  seq_pattern_tx #(.GAP_CYCLES(2), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .start(start), .data(data), .len(len),
    .repeat_en(repeat_en), .abort(abort), .x1(x1_m), .ready(ready_m),
    .busy(busy_m), .done(done_m), .bit_idx(idx_m), .frame_cnt(fc_m));

  seq_pattern_tx #(.GAP_CYCLES(2), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .start(start), .data(data), .len(len),
    .repeat_en(repeat_en), .abort(abort), .x1(x1_l), .ready(ready_l),
    .busy(busy_l), .done(done_l), .bit_idx(idx_l), .frame_cnt(fc_l));

  typedef struct packed {
    logic       x1;
    logic       ready;
    logic       busy;
    logic       done;
    logic [2:0] bit_idx;
    logic [3:0] fc;
  } exp_t;

  typedef struct {
    logic rst;
    logic start;
    logic abort;
    exp_t e;
  } vec_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         sel_lsb  = 1'b0;
  logic [3:0] fc_model;

  function automatic exp_t mk(input logic x, input logic r, input logic b,
                              input logic d, input logic [2:0] i, input logic [3:0] f);
    exp_t e;
    e.x1 = x; e.ready = r; e.busy = b; e.done = d; e.bit_idx = i; e.fc = f;
    return e;
  endfunction

  function automatic exp_t idle_e(input logic [3:0] f);
    return mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, f);
  endfunction

  task automatic check(input string tag, input exp_t e);
    exp_t a;
    a = sel_lsb ? {x1_l, ready_l, busy_l, done_l, idx_l, fc_l}
                : {x1_m, ready_m, busy_m, done_m, idx_m, fc_m};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: actual x1=%0b ready=%0b busy=%0b done=%0b bit_idx=%0d frame_cnt=%0d required x1=%0b ready=%0b busy=%0b done=%0b bit_idx=%0d frame_cnt=%0d",
               tag, $time, a.x1, a.ready, a.busy, a.done, a.bit_idx, a.fc,
               e.x1, e.ready, e.busy, e.done, e.bit_idx, e.fc);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: scoreboard empty, actual x1=%0b required a queued record", tag, x1_m);
      end else begin
        check(tag, exp_q.pop_front());
      end
    end
  endtask

  task automatic drain_all(input string tag);
    drain(tag, exp_q.size());
  endtask

  // Expected cycles of one frame: len+1 bits, two gap cycles, optional DONE then IDLE.
  task automatic push_frame(input logic [7:0] d, input int ln, input bit msb, input bit finish);
    logic b;
    for (int k = 0; k <= ln; k++) begin
      b = msb ? d[ln - k] : d[k];
      exp_q.push_back(mk(b, 1'b0, 1'b1, 1'b0, 3'(k), fc_model));
    end
    fc_model = fc_model + 4'd1;
    for (int g = 0; g < 2; g++) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, fc_model));
    if (finish) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, fc_model));
      exp_q.push_back(idle_e(fc_model));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; repeat_en = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    exp_q.delete();
    fc_model = 4'd0;
  endtask

  vec_t vecs[5];

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; repeat_en = 1'b0;
    data = 8'h00; len = 3'd0; fc_model = 4'd0;

    vecs[0] = '{rst: 1'b1, start: 1'b1, abort: 1'b1, e: idle_e(4'd0)};
    vecs[1] = '{rst: 1'b1, start: 1'b1, abort: 1'b0, e: idle_e(4'd0)};
    vecs[2] = '{rst: 1'b0, start: 1'b1, abort: 1'b1, e: idle_e(4'd0)};
    vecs[3] = '{rst: 1'b0, start: 1'b0, abort: 1'b0, e: idle_e(4'd0)};
    vecs[4] = '{rst: 1'b0, start: 1'b0, abort: 1'b1, e: idle_e(4'd0)};

    data = 8'hFF; len = 3'd7;
    for (int v = 0; v < 5; v++) begin
      rst = vecs[v].rst; start = vecs[v].start; abort = vecs[v].abort;
      cyc();
      check($sformatf("vec%0d", v), vecs[v].e);
    end
    start = 1'b0; abort = 1'b0;

    // B4, 8 bits, MSB first
    do_reset();
    data = 8'hB4; len = 3'd7; start = 1'b1;
    push_frame(8'hB4, 7, 1'b1, 1'b1);
    drain("b4_msb", 1);
    start = 1'b0;
    drain_all("b4_msb");

    // 05, 3 bits, LSB first, repeated three times
    do_reset();
    sel_lsb = 1'b1;
    data = 8'h05; len = 3'd2; repeat_en = 1'b1; start = 1'b1;
    push_frame(8'h05, 2, 1'b0, 1'b0);
    push_frame(8'h05, 2, 1'b0, 1'b0);
    push_frame(8'h05, 2, 1'b0, 1'b1);
    drain("rep_lsb", 1);
    start = 1'b0; data = 8'hFA; len = 3'd6;
    drain("rep_lsb", 13);
    repeat_en = 1'b0;
    drain_all("rep_lsb");
    sel_lsb = 1'b0;

    // abort on the 4th bit
    do_reset();
    data = 8'hA5; len = 3'd7; start = 1'b1;
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk(8'hA5 >> (7 - k) & 8'h01 ? 1'b1 : 1'b0, 1'b0, 1'b1, 1'b0, 3'(k), 4'd0));
    drain("abort", 1);
    start = 1'b0;
    drain("abort", 3);
    abort = 1'b1;
    cyc();
    check("abort_idle", idle_e(4'd0));
    abort = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back(idle_e(4'd0));
    drain_all("abort_after");

    // second start while busy, data changed mid-frame
    data = 8'hC3; len = 3'd5; start = 1'b1;
    push_frame(8'hC3, 5, 1'b1, 1'b1);
    drain("busy_start", 1);
    data = 8'h3C; len = 3'd3;
    drain("busy_start", 3);
    start = 1'b0; data = 8'h00;
    drain_all("busy_start");

    // 17 one-bit frames: frame_cnt wraps through 0
    do_reset();
    data = 8'h01; len = 3'd0; repeat_en = 1'b1; start = 1'b1;
    for (int f = 0; f < 16; f++) push_frame(8'h01, 0, 1'b1, 1'b0);
    push_frame(8'h01, 0, 1'b1, 1'b1);
    drain("wrap", 1);
    start = 1'b0;
    drain("wrap", 49);
    repeat_en = 1'b0;
    drain_all("wrap");

    // rst during GAP, then start+abort in IDLE
    do_reset();
    data = 8'hB4; len = 3'd7; start = 1'b1;
    push_frame(8'hB4, 7, 1'b1, 1'b1);
    drain("rst_gap", 1);
    start = 1'b0;
    drain("rst_gap", 8);
    exp_q.delete();
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    cyc();
    check("rst_in_gap", idle_e(4'd0));
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    cyc();
    check("after_rst", idle_e(4'd0));
    start = 1'b1; abort = 1'b1;
    cyc();
    check("start_abort", idle_e(4'd0));
    start = 1'b0; abort = 1'b0;
    cyc();
    check("start_abort_hold", idle_e(4'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 2, giving the number of idle (x1=0) cycles after each frame; legal range 1..15.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 sends the highest selected bit first and 0 sends bit 0 first.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port start  input  1  frame request, sampled each clock.
REQ-006 The block SHALL have port data  input  8  pattern bits, latched on an accepted start.
REQ-007 The block SHALL have port len  input  3  frame length minus one (0 -> 1 bit, 7 -> 8 bits), latched on an accepted start.
REQ-008 The block SHALL have port repeat_en  input  1  high means retransmit the latched pattern after the gap.
REQ-009 The block SHALL have port abort  input  1  terminate any activity.
REQ-010 The block SHALL have port x1  output  1  registered serial bit stream for the sequence-detector input.
REQ-011 The block SHALL have port ready  output  1  high only in IDLE; start is accepted only when it is high.
REQ-012 The block SHALL have port busy  output  1  high in SEND and GAP.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse at normal frame-sequence completion.
REQ-014 The block SHALL have port bit_idx  output  3  index of the bit currently on x1 within the frame, counting from 0.
REQ-015 The block SHALL have port frame_cnt  output  4  count of frames fully sent; wraps from 15 to 0.

Function
REQ-016 The block SHALL be a Moore machine with states IDLE, SEND, GAP and DONE, and all outputs SHALL be registered functions of state only.
REQ-017 In IDLE, start=1 with abort=0 SHALL latch data and len and enter SEND on the next edge; start in any other state SHALL be ignored.
REQ-018 If start is accepted at edge T, x1 SHALL carry the first bit with bit_idx=0 and busy=1 in cycle T+1, and bit k SHALL be on x1 in cycle T+1+k.
REQ-019 With MSB_FIRST=1, the bit order SHALL be data[len], data[len-1], ..., data[0]; with MSB_FIRST=0, it SHALL be data[0], ..., data[len].
REQ-020 After bit index len, the block SHALL enter GAP for exactly GAP_CYCLES cycles with x1=0 and bit_idx=0.
REQ-021 frame_cnt SHALL increment by 1, modulo 16, on the edge leaving the last bit of a frame.
REQ-022 In the last GAP cycle, if repeat_en=1, the block SHALL return to SEND and resend the latched pattern; new data and len SHALL NOT be sampled.
REQ-023 In the last GAP cycle, if repeat_en=0, the block SHALL enter DONE for one cycle (done=1, x1=0, busy=0, ready=0) and then enter IDLE.
REQ-024 For a single frame with start at T, DONE SHALL occur at T+2+len+GAP_CYCLES and ready SHALL return at T+3+len+GAP_CYCLES.
REQ-025 abort=1 SHALL force IDLE on the next edge from any state: x1=0, no done pulse, frame_cnt unchanged, partial frame not counted.
REQ-026 If abort and start are both high in IDLE, abort SHALL win and the block SHALL stay in IDLE.
REQ-027 Changes to data or len while busy SHALL NOT affect the frame in progress or any repeated frame.
REQ-028 For len=0, each frame SHALL be one bit long followed by the gap.

Reset
REQ-029 rst=1 at a clock edge SHALL override abort and start, and SHALL force IDLE, x1=0, ready=1, busy=0, done=0, bit_idx=0 and frame_cnt=0.
REQ-030 rst asserted mid-frame SHALL discard the latched pattern, and the first cycle after rst deasserts SHALL show ready=1.

Verification
REQ-031 The bench SHALL cover: start, data=8'hB4, len=7, MSB_FIRST=1, GAP=2 -> x1 = 1,0,1,1,0,1,0,0, then 0,0, then done pulse, then frame_cnt=1 and ready=1.
REQ-032 The bench SHALL cover: data=8'h05, len=2, MSB_FIRST=0, repeat_en=1 for 3 frames -> x1 pattern 1,0,1,0,0 repeated, frame_cnt steps 1,2,3, and no done until repeat_en drops.
REQ-033 The bench SHALL cover: abort during the 4th bit of a len=7 frame -> IDLE next cycle, x1=0, done never asserted, frame_cnt unchanged.
REQ-034 The bench SHALL cover: a start pulse while busy, with data changed mid-frame -> the second start is ignored and the transmitted bits match the original data.
REQ-035 The bench SHALL cover: repeat mode held for 17 one-bit frames -> frame_cnt wraps from 15 to 0 and then reads 1.
REQ-036 The bench SHALL cover: rst during GAP, and start together with abort in IDLE -> after rst all outputs equal the reset values, and start+abort leaves ready=1 and busy=0.
